// File: rtl/fp_pkg.sv
// Shared single-precision definitions for the FP datapath: field widths,
// special encodings, divider working widths and the divider FSM states.
package fp_pkg;

  localparam int E_W  = 8;
  localparam int M_W  = 23;
  localparam int FP_W = 1 + E_W + M_W;
  localparam int BIAS = 127;
  localparam logic [E_W-1:0] EXP_MAX = 8'hFF;

  // Signed working exponent wide enough for EA-EB+BIAS over all encodings.
  localparam int X_W = 10;
  localparam int R_W = M_W + 3;
  localparam int Q_W = M_W + 2;
  localparam int DIV_ITERS = 25;
  localparam int CNT_W = 5;

  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
  localparam logic [FP_W-1:0] FP_NEG_INF  = 32'hFF80_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } fp_div_state_e;

  function automatic logic signed [X_W-1:0] biased_exp_diff(
    input logic [E_W-1:0] ea,
    input logic [E_W-1:0] eb
  );
    return $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(X_W'(BIAS));
  endfunction

  function automatic logic [FP_W-1:0] fp_inf(input logic s);
    return s ? FP_NEG_INF : FP_POS_INF;
  endfunction

  function automatic logic [FP_W-1:0] fp_zero(input logic s);
    return s ? FP_NEG_ZERO : FP_POS_ZERO;
  endfunction

endpackage

// File: rtl/fp_div_if.sv
// Start/done handshake bundle between a requester and the FP divider.
// start is honoured only while busy=0; done pulses one cycle with OUT valid,
// and OUT then holds until a later start is accepted.
interface fp_div_if;
  import fp_pkg::*;

  logic            start;
  logic [FP_W-1:0] A;
  logic [FP_W-1:0] B;
  logic            busy;
  logic            done;
  logic [FP_W-1:0] OUT;

  modport master (output start, A, B, input busy, done, OUT);
  modport slave  (input start, A, B, output busy, done, OUT);

endinterface

// File: rtl/fp_div.sv
// Sequential single-precision divider: restoring radix-2 mantissa division,
// one quotient bit per cycle, truncating result, fixed 26-cycle latency.
module fp_div
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp_div_if.slave       bus,
  output fp_div_state_e dbg_state_o
);

  fp_div_state_e           state_q;
  logic                    so_q;
  logic                    a_zero_q;
  logic                    b_zero_q;
  logic signed [X_W-1:0]   xe_q;
  logic [M_W:0]            mb_q;
  logic [R_W-1:0]          r_q;
  logic [Q_W-1:0]          q_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic [FP_W-1:0]         out_q;

  logic [E_W-1:0]          ea;
  logic [E_W-1:0]          eb;
  logic [M_W:0]            ma;
  logic [M_W:0]            mb;
  logic                    so;
  logic signed [X_W-1:0]   xe_start;

  logic [R_W-1:0]          r_cmp;
  logic                    take;
  logic [R_W-1:0]          r_rem;
  logic [R_W-1:0]          r_d;
  logic [Q_W-1:0]          q_d;
  logic signed [X_W-1:0]   xe_n;
  logic [M_W-1:0]          frac;
  logic [FP_W-1:0]         out_d;

  always_comb begin
    ea       = bus.A[FP_W-2:M_W];
    eb       = bus.B[FP_W-2:M_W];
    ma       = {1'b1, bus.A[M_W-1:0]};
    mb       = {1'b1, bus.B[M_W-1:0]};
    so       = bus.A[FP_W-1] ^ bus.B[FP_W-1];
    xe_start = biased_exp_diff(ea, eb);
  end

  // One restoring step: subtract when the partial remainder covers the divisor.
  always_comb begin
    r_cmp = {2'b00, mb_q};
    take  = (r_q >= r_cmp);
    r_rem = take ? (r_q - r_cmp) : r_q;
    r_d   = r_rem << 1;
    q_d   = {q_q[Q_W-2:0], take};
  end

  // Quotient lies in (0.5, 2): Q[24] tells whether it needs a one-place renormalise.
  always_comb begin
    xe_n  = q_q[Q_W-1] ? xe_q : (xe_q - 10'sd1);
    frac  = q_q[Q_W-1] ? q_q[M_W:1] : q_q[M_W-1:0];
    out_d = {so_q, xe_n[E_W-1:0], frac};
    if (b_zero_q) begin
      out_d = fp_inf(so_q);
    end else if (a_zero_q) begin
      out_d = fp_zero(so_q);
    end else if (xe_n >= $signed({2'b00, EXP_MAX})) begin
      out_d = fp_inf(so_q);
    end else if (xe_n <= 10'sd0) begin
      out_d = fp_zero(so_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      so_q     <= 1'b0;
      a_zero_q <= 1'b0;
      b_zero_q <= 1'b0;
      xe_q     <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            so_q     <= so;
            a_zero_q <= (ea == '0);
            b_zero_q <= (eb == '0);
            xe_q     <= xe_start;
            mb_q     <= mb;
            r_q      <= {2'b00, ma};
            q_q      <= '0;
            cnt_q    <= CNT_W'(DIV_ITERS - 1);
            busy_q   <= 1'b1;
            state_q  <= DIV;
          end
        end
        DIV: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIN: begin
          out_q   <= out_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.OUT     = out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed and random divides through a
// scoreboard queue, plus latency, handshake and mid-operation reset checks.
module tb_fp_div;
  import fp_pkg::*;

  logic          clk;
  logic          rst;
  fp_div_state_e dbg_state;

  fp_div_if bus();

  fp_div dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int          n_tests;
  int          n_fail;
  int          n_done;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  // Reference: integer long division of the mantissas, then normalise/truncate.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              e;
    longint unsigned ma;
    longint unsigned mb;
    longint unsigned q;
    logic [22:0]     f;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'd0) return {s, 31'h0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    q  = (ma << 24) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= 64'd16777216) begin
      f = q[23:1];
    end else begin
      f = q[22:0];
      e = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], f};
  endfunction

  // scoreboard: every done pops the oldest expected result
  always @(negedge clk) begin
    if (bus.done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check32("sb_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        sb_exp = exp_q.pop_front();
        check32("out", bus.OUT, sb_exp);
      end
    end
  end

  // driver tasks
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back(expv);
    @(negedge clk);
    bus.start = 1'b0;
    check32("busy_on_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.done) seen = 1'b1;
    end
    check32({tag, "_lat"}, 32'(n), 32'(lat));
    if (seen) begin
      check32({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check32({tag, "_done_width"}, 32'(bus.done), 32'd0);
    end
  endtask

  logic [31:0] dir_a [7];
  logic [31:0] dir_b [7];
  logic [31:0] dir_e [7];

  initial begin
    int d0;
    logic [31:0] ra;
    logic [31:0] rb;

    n_tests = 0;
    n_fail  = 0;
    n_done  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check32("rst_busy", 32'(bus.busy), 32'd0);
    check32("rst_done", 32'(bus.done), 32'd0);
    check32("rst_out", bus.OUT, 32'h0);
    check32("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    dir_a = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h3F800000,
              32'h80000000, 32'h7F000000, 32'h00800000};
    dir_b = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000,
              32'h40A00000, 32'h3E800000, 32'h4B000000};
    dir_e = '{32'h40400000, 32'h3EAAAAAA, 32'hC1800000, 32'h7F800000,
              32'h80000000, 32'h7F800000, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      launch(dir_a[i], dir_b[i], dir_e[i]);
      wait_done("dir", 26);
    end

    for (int i = 0; i < 16; i++) begin
      if (i < 10) begin
        ra = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 164)), 23'($urandom)};
        rb = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 164)), 23'($urandom)};
      end else begin
        ra = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
        rb = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 254)), 23'($urandom)};
      end
      launch(ra, rb, model(ra, rb));
      wait_done("rnd", 26);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // start while busy must not disturb the in-flight divide
    launch(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 32'h3F800000;
    bus.B     = 32'h40400000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("busy_ign", 15);

    // start held across the FIN edge: ignored there, accepted one edge later
    launch(32'hC1000000, 32'h3F000000, 32'hC1800000);
    repeat (25) @(negedge clk);
    check32("busy_in_fin", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.A     = 32'h40C00000;
    bus.B     = 32'h40000000;
    exp_q.push_back(32'h40400000);
    @(negedge clk);
    check32("fin_done", 32'(bus.done), 32'd1);
    check32("fin_start_ignored", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check32("next_start_accepted", 32'(bus.busy), 32'd1);
    wait_done("b2b", 26);

    // reset in the middle of a divide
    launch(32'h40C00000, 32'h40000000, 32'h40400000);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("abort_busy", 32'(bus.busy), 32'd0);
    check32("abort_done", 32'(bus.done), 32'd0);
    check32("abort_out", bus.OUT, 32'h0);
    check32("abort_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    void'(exp_q.pop_back());
    d0 = n_done;
    repeat (40) @(negedge clk);
    check32("abort_no_done", 32'(n_done - d0), 32'd0);
    launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    wait_done("post_rst", 26);

    repeat (5) @(negedge clk);
    check32("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div.md
# fp_div

Sequential single-precision floating-point divider, OUT = A / B, the inverse companion to the combinational FP multiplier in the FP datapath. It uses the same 32-bit format (S, 8-bit E, 23-bit M, bias 127) and the same truncating, no-rounding arithmetic. A restoring radix-2 mantissa divider produces one quotient bit per cycle, behind a start/done handshake, so no wide combinational divider is needed.

## Interface
- No parameters; all widths come from the shared package.
- clk  in  1  system clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; accepted only when busy=0.
- A  in  32  dividend; sampled on the accepted start.
- B  in  32  divisor; sampled on the accepted start.
- busy  out  1  divide in progress.
- done  out  1  one-cycle pulse; OUT is valid on this cycle.
- OUT  out  32  quotient; held until the next accepted start.

## Operation
- **Operand decode**
  - An operand with E==0 is treated as zero; denormals are flushed.
  - Hidden bit is 1 for all nonzero operands: MA={1,A[22:0]}, MB={1,B[22:0]}.
  - SO=SA^SB in all cases, including special cases.
- **FSM states**
  - IDLE: on start, latch SO, MA, MB, zero flags, and the 10-bit signed exponent EA-EB+127. Clear R={2'b0,MA} and Q. Go to DIV.
  - DIV: 25 iterations.
    - If R>=MB: Q={Q,1}, R=(R-MB)<<1.
    - Else: Q={Q,0}, R=R<<1.
    - R is 26 bits; Q is 25 bits.
    - After iteration 25, go to FIN.
  - FIN: compute OUT, pulse done, go to IDLE.
- **Normalization in FIN**
  - If Q[24]=1: fraction=Q[23:1], exponent unchanged.
  - Else: fraction=Q[22:0], exponent -1.
  - Truncate; no rounding.
- **Result priority in FIN, highest first**
  1. B zero (including 0/0): OUT={SO,8'hFF,23'h0}.
  2. A zero: OUT={SO,31'h0}.
  3. Exponent >=255: OUT={SO,8'hFF,23'h0}.
  4. Exponent <=0: OUT={SO,31'h0}.
  5. Otherwise: OUT={SO,exponent[7:0],fraction}.
- **Special cases** do not shortcut: latency is fixed for all operands.
- **start while busy**: ignored; in-flight operands are unaffected.
- **start on the done cycle**: ignored (FSM is in FIN). A start on the following cycle is accepted.

## Timing
- Reset values: state=IDLE, busy=0, done=0, OUT=32'h0, R/Q/exponent registers 0.
- Reset asserted mid-divide aborts it:
  - next cycle is IDLE with busy=0, done=0, OUT=0;
  - no done pulse for the aborted operation.
- Start accepted at edge 0. busy=1 from edge 0 through edge 25, covering 25 DIV cycles.
- FIN is the cycle after edge 25. done=1 and OUT is valid after edge 26; latency is 26 cycles from start.
- busy=0 on the done cycle; done is high for exactly one cycle.
- Back-to-back throughput: one result per 27 cycles.

## Structure
- Package fp_pkg holds:
  - FP field widths: E_W=8, M_W=23.
  - BIAS=127, EXP_MAX=8'hFF.
  - Constants FP_POS_ZERO, FP_NEG_ZERO, FP_POS_INF, FP_NEG_INF.
  - An enum for the FSM states IDLE/DIV/FIN.
- Single module, no sub-module. The iteration counter is a 5-bit down-counter loaded with 24.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> OUT=0x40400000 after exactly 26 cycles; done high for 1 cycle; busy low on the done cycle.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- 0xC1000000 / 0x3F000000 (-8/0.5) -> 0xC1800000.
- Special cases:
  - 0x3F800000 / 0x00000000 -> 0x7F800000.
  - 0x80000000 / 0x40A00000 -> 0x80000000.
  - 0x7F000000 / 0x3E800000 (overflow) -> 0x7F800000.
  - 0x00800000 / 0x4B000000 (underflow) -> 0x00000000.
- Handshake:
  - start with new operands at cycle 10 of a 6/2 divide -> ignored; result is still 0x40400000.
  - start on the done cycle -> ignored; start on the next cycle -> accepted.
- Reset at cycle 12 of a divide -> busy=0, done=0, OUT=0 next cycle, no done pulse. A new start after reset completes normally in 26 cycles.
